// File: rtl/alu_pkg.sv
// Shared opcode, flag and state definitions for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_ORR = 4'b0011,
    OP_EOR = 4'b0100,
    OP_MOV = 4'b0101,
    OP_CMP = 4'b0110,
    OP_MUL = 4'b0111,
    OP_LDR = 4'b1000,
    OP_STR = 4'b1001,
    OP_LDM = 4'b1010
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  // STR computes an address only, so it never touches the flag register.
  function automatic logic is_flag_op(alu_op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_MOV,
      OP_CMP, OP_MUL, OP_LDR, OP_LDM: is_flag_op = 1'b1;
      default:                         is_flag_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic             busy;

  // product is the accumulator after the current step, so the final value
  // is available in the same cycle that done pulses.
  assign acc_next = b_sh[0] ? (acc + a_sh) : acc;
  assign product  = acc_next;
  assign done     = busy && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      a_sh <= a;
      b_sh <= b;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc  <= acc_next;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle datapath, iterative MUL, NZCV register,
// valid/ready handshakes on both sides.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  input  logic             SetFlags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             out_err,
  output logic [3:0]       ALUFlags
);

  alu_op_e          op;
  state_e           state;
  flags_t           flags;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_err;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic             mul_set;

  assign op        = alu_op_e'(ALUControl);
  assign ALUFlags  = flags;
  assign is_mul    = (op == OP_MUL) && MUL_EN;
  assign mul_start = (state == IDLE) && in_valid && is_mul;
  assign sum       = {1'b0, A} + {1'b0, B};
  assign diff      = {1'b0, A} - {1'b0, B};

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_product)
  );

  // Logical ops pass the current C/V through so a commit leaves them intact.
  always_comb begin
    alu_res = '0;
    alu_c   = flags.c;
    alu_v   = flags.v;
    alu_err = 1'b0;
    case (op)
      OP_ADD, OP_LDR, OP_LDM, OP_STR: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = ~diff[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_ORR:  alu_res = A | B;
      OP_EOR:  alu_res = A ^ B;
      OP_MOV:  alu_res = B;
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Result    <= '0;
      out_err   <= 1'b0;
      flags     <= '0;
      mul_set   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_mul) begin
              mul_set <= SetFlags;
              state   <= MUL;
            end else begin
              Result    <= alu_res;
              out_err   <= alu_err;
              out_valid <= 1'b1;
              state     <= DONE;
              if (SetFlags && !alu_err && is_flag_op(op))
                flags <= '{n: alu_res[WIDTH-1], z: (alu_res == '0),
                           c: alu_c, v: alu_v};
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            Result    <= mul_product;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
            if (mul_set) begin
              flags.n <= mul_product[WIDTH-1];
              flags.z <= (mul_product == '0);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed table-driven bench for alu_mc plus backpressure and reset-abort sequences.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUControl;
  logic        SetFlags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        out_err;
  logic [3:0]  ALUFlags;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sf;
    logic [31:0] res;
    logic        err;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  alu_mc #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .SetFlags   (SetFlags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .out_err    (out_err),
    .ALUFlags   (ALUFlags)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns cycles until out_valid.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic sf, output int lat, output int busy);
    A = a;
    B = b;
    ALUControl = op;
    SetFlags = sf;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    busy = in_ready ? 0 : 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (!in_ready) busy++;
    end
  endtask

  initial begin
    int lat;
    int busy;
    int seen;

    vecs[0]  = '{4'b0000, 32'hFFFF_FFFF, 32'h1,         1'b1, 32'h0,         1'b0, 4'b0110, 1};
    vecs[1]  = '{4'b0110, 32'd5,         32'd7,         1'b1, 32'hFFFF_FFFE, 1'b0, 4'b1000, 1};
    vecs[2]  = '{4'b0011, 32'h0,         32'h0,         1'b1, 32'h0,         1'b0, 4'b0100, 1};
    vecs[3]  = '{4'b0000, 32'h7FFF_FFFF, 32'h1,         1'b1, 32'h8000_0000, 1'b0, 4'b1001, 1};
    vecs[4]  = '{4'b1001, 32'h0,         32'h0,         1'b1, 32'h0,         1'b0, 4'b1001, 1};
    vecs[5]  = '{4'b0001, 32'd7,         32'd5,         1'b1, 32'd2,         1'b0, 4'b0010, 1};
    vecs[6]  = '{4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000, 1'b0, 4'b0010, 1};
    vecs[7]  = '{4'b0100, 32'hAAAA_AAAA, 32'h0,         1'b1, 32'hAAAA_AAAA, 1'b0, 4'b1010, 1};
    vecs[8]  = '{4'b0101, 32'd123,       32'h0,         1'b1, 32'h0,         1'b0, 4'b0110, 1};
    vecs[9]  = '{4'b1000, 32'h1000,      32'h20,        1'b1, 32'h1020,      1'b0, 4'b0000, 1};
    vecs[10] = '{4'b0001, 32'h8000_0000, 32'h1,         1'b1, 32'h7FFF_FFFF, 1'b0, 4'b0011, 1};
    vecs[11] = '{4'b1010, 32'hFFFF_FFF0, 32'h10,        1'b0, 32'h0,         1'b0, 4'b0011, 1};
    vecs[12] = '{4'b1011, 32'd9,         32'd9,         1'b1, 32'h0,         1'b1, 4'b0011, 1};
    vecs[13] = '{4'b0111, 32'd1234,      32'd5678,      1'b0, 32'd7006652,   1'b0, 4'b0011, 33};
    vecs[14] = '{4'b0111, 32'h1_0000,    32'h1_0000,    1'b1, 32'h0,         1'b0, 4'b0111, 33};
    vecs[15] = '{4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h1,         1'b0, 4'b0011, 33};
    vecs[16] = '{4'b0000, 32'd1,         32'd2,         1'b0, 32'd3,         1'b0, 4'b0011, 1};

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    ALUControl = '0;
    SetFlags = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset Result", Result, 0);
    checkOutput("reset out_err", out_err, 0);
    checkOutput("reset ALUFlags", ALUFlags, 0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sf, lat, busy);
      checkOutput($sformatf("v%0d latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("v%0d busy cycles", i), busy, vecs[i].lat);
      checkOutput($sformatf("v%0d Result", i), Result, vecs[i].res);
      checkOutput($sformatf("v%0d out_err", i), out_err, vecs[i].err);
      checkOutput($sformatf("v%0d ALUFlags", i), ALUFlags, vecs[i].flags);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d drained in_ready", i), in_ready, 1);
      checkOutput($sformatf("v%0d drained out_valid", i), out_valid, 0);
    end

    // Unimplemented opcode held under backpressure while new requests are offered.
    out_ready = 1'b0;
    applyStimulus(4'b1111, 32'd5, 32'd6, 1'b1, lat, busy);
    checkOutput("unimpl latency", lat, 1);
    checkOutput("unimpl out_err", out_err, 1);
    checkOutput("unimpl Result", Result, 0);
    checkOutput("unimpl ALUFlags", ALUFlags, 4'b0011);
    A = 32'd1;
    B = 32'd1;
    ALUControl = 4'b0000;
    SetFlags = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold%0d out_valid", c), out_valid, 1);
      checkOutput($sformatf("hold%0d Result", c), Result, 0);
      checkOutput($sformatf("hold%0d out_err", c), out_err, 1);
      checkOutput($sformatf("hold%0d in_ready", c), in_ready, 0);
      checkOutput($sformatf("hold%0d ALUFlags", c), ALUFlags, 4'b0011);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("drain no same-cycle accept", out_valid, 0);
    checkOutput("drain in_ready", in_ready, 1);
    checkOutput("drain flags untouched", ALUFlags, 4'b0011);

    // Reset ten cycles into a MUL, with a competing request on the reset edge.
    A = 32'd3;
    B = 32'd3;
    ALUControl = 4'b0111;
    SetFlags = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("abort mul busy", in_ready, 0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    ALUControl = 4'b0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    checkOutput("abort out_valid", out_valid, 0);
    checkOutput("abort in_ready", in_ready, 1);
    checkOutput("abort ALUFlags", ALUFlags, 0);
    checkOutput("abort Result", Result, 0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkOutput("abort no late result", seen, 0);
    checkOutput("abort flags stay clear", ALUFlags, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Handles ADD/SUB/AND/ORR/EOR/MOV/CMP and address-add ops in one cycle, and an iterative shift-add MUL over WIDTH cycles.
- Holds an architectural NZCV flag register, updated only when SetFlags is asserted.
- Sits between the register-file read stage and writeback, using valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand/result width in bits (>=8).
MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as unimplemented.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept a request
A  input  WIDTH  operand A
B  input  WIDTH  operand B
ALUControl  input  4  opcode
SetFlags  input  1  commit flags of this op to the flag register
out_valid  output  1  Result/out_err valid
out_ready  input  1  consumer accepts result
Result  output  WIDTH  registered result
out_err  output  1  opcode unimplemented
ALUFlags  output  4  flag register {N,Z,C,V}

Behaviour:
- One clock; reset is synchronous and active-high on clk/reset.
- Reset values: state IDLE, in_ready=1, out_valid=0, Result=0, out_err=0, ALUFlags=0000.
- Reset mid-MUL or mid-DONE aborts the op. The result is discarded and flags are not committed.
- Opcodes:
  - 0000 ADD, 1000 LDR, 1010 LDM: A+B.
  - 0001 SUB, 0110 CMP: A-B.
  - 0010 AND, 0011 ORR, 0100 EOR: bitwise ops.
  - 0101 MOV: B.
  - 1001 STR: A+B, never updates flags even with SetFlags.
  - 0111 MUL: low WIDTH bits of A*B, unsigned.
  - All others, including 1011, and MUL with MUL_EN=0: unimplemented.
- Arithmetic is computed at WIDTH+1 bits.
  - ADD: C = carry-out.
  - SUB/CMP: C = NOT borrow (A>=B unsigned), ARM convention.
  - V = signed overflow.
  - N = Result[WIDTH-1]; Z = (Result==0).
- Logical ops, MOV and MUL update N and Z only; C and V keep their current register value.
- Unimplemented opcode: Result=0, out_err=1, flags unchanged regardless of SetFlags.
- Flag register writes only on the cycle the op completes (enters DONE), and only if SetFlags=1 and the op is flag-capable.
- The ALUFlags output always reflects the register, so a new value is visible the cycle after completion.
- FSM:
  - IDLE: in_ready=1. On in_valid, a non-MUL op computes and goes to DONE next cycle (latency 1). MUL latches A, B, clears the accumulator and counter, and goes to MUL.
  - MUL: in_ready=0. Each cycle, if B_sh[0] then acc+=A_sh; then A_sh<<=1, B_sh>>=1, cnt++. After WIDTH iterations, go to DONE. Acceptance in cycle t gives out_valid at t+WIDTH+1.
  - DONE: out_valid=1, in_ready=0. Result and out_err stay stable until out_ready. On out_ready go to IDLE; in_ready returns the next cycle, so there is no same-cycle accept-on-drain.
- Backpressure: out_ready low holds DONE indefinitely with no flag re-commit.
- Inputs are ignored whenever in_ready=0.
- Simultaneous reset and in_valid: reset wins.
- MUL overflow wraps silently; upper product bits are discarded.

Decomposition:
- Package alu_pkg:
  - typedef enum logic[3:0] alu_op_e with the opcode values above.
  - typedef struct flags_t {n,z,c,v}.
  - typedef enum state_e {IDLE, MUL, DONE}.
  - function is_flag_op(alu_op_e).
- Sub-module alu_mul_iter(WIDTH): shift-add multiplier with start/done pulse, owning the accumulator and counter.
- The top level holds the FSM, combinational single-cycle datapath, flag register and output registers.

Test Plan:
- Reset, then ADD A=0xFFFFFFFF, B=1, SetFlags=1 -> out_valid one cycle after accept; Result=0; ALUFlags=0110 (Z,C).
- CMP A=5, B=7, SetFlags=1 -> Result=0xFFFFFFFE, ALUFlags=1000. Then ORR A=0, B=0, SetFlags=1 -> Result=0, ALUFlags=0100 (C,V preserved as 0,0).
- ADD A=0x7FFFFFFF, B=1, SetFlags=1 -> Result=0x80000000, flags=1001. Then STR A=0, B=0, SetFlags=1 -> flags remain 1001.
- MUL A=1234, B=5678 -> in_ready low for 33 cycles, out_valid at accept+33, Result=7006652. Then MUL 0x10000 by 0x10000 -> Result=0, Z=1 if SetFlags.
- Opcode 1111 with SetFlags=1 -> out_err=1, Result=0, flags unchanged. Then hold out_ready=0 for 5 cycles -> out_valid and Result stable, in_valid ignored.
- Assert reset 10 cycles into a MUL -> next cycle out_valid=0, in_ready=1, ALUFlags=0000; no result is ever emitted for the aborted op.
